// File: rtl/vout_timing_gen.sv
// Video output timing generator: shadowed H/V timing, sync polarity, valid/ready pixel pull,
// sticky underflow. Optional colour bars when VOUT_TIMING_TEST_PATTERN_EN is defined.
`timescale 1ns/1ps
module vout_timing_gen #(
  parameter int H_WIDTH    = 12,
  parameter int V_WIDTH    = 12,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync_en,
  input  logic                         cfg_load_i,
  input  logic                         hpol_i,
  input  logic                         vpol_i,
  input  logic [H_WIDTH-1:0]           hfp_i,
  input  logic [H_WIDTH-1:0]           hsw_i,
  input  logic [H_WIDTH-1:0]           hbp_i,
  input  logic [H_WIDTH-1:0]           hactive_i,
  input  logic [V_WIDTH-1:0]           vfp_i,
  input  logic [V_WIDTH-1:0]           vsw_i,
  input  logic [V_WIDTH-1:0]           vbp_i,
  input  logic [V_WIDTH-1:0]           vactive_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] pix_data_i,
  input  logic                         pix_valid_i,
  input  logic                         underflow_clr_i,
`ifdef VOUT_TIMING_TEST_PATTERN_EN
  input  logic                         test_pat_i,
`endif
  output logic                         pix_ready_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] pix_data_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic                         de_o,
  output logic                         frame_start_o,
  output logic                         underflow_o
);

  localparam int HW = H_WIDTH + 2;
  localparam int VW = V_WIDTH + 2;
  localparam int PW = NUM_CH * DATA_WIDTH;
  localparam logic [HW-1:0] H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};

  logic [H_WIDTH-1:0] hfp_r, hsw_r, hbp_r, hact_r;
  logic [V_WIDTH-1:0] vfp_r, vsw_r, vbp_r, vact_r;
  logic               hpol_r, vpol_r, pend_r;
  logic [HW-1:0]      h_cnt_r, h_cnt_nxt_s, htot_s, hsw_end_s, hact_start_s;
  logic [VW-1:0]      v_cnt_r, v_cnt_nxt_s, vtot_s, vsw_end_s, vact_start_s;
  logic               h_last_s, v_last_s, shadow_load_s;
  logic               h_sync_s, h_act_s, v_sync_s, v_act_s, active_s, ready_s;
  logic               uf_set_s, uf_nxt_s;
  logic [PW-1:0]      data_nxt_s;
  logic               hsync_r, vsync_r, de_r, fs_r, underflow_r;
  logic [PW-1:0]      pix_data_r;

`ifdef VOUT_TIMING_TEST_PATTERN_EN
  logic [HW-1:0]      hoff_s;

  // Bar 0 is white, bar 7 black: a channel is lit while its bar bit is clear.
  function automatic logic [PW-1:0] bar_pixel(input logic [2:0] bar);
    logic [PW-1:0] pix;
    pix = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pix[k*DATA_WIDTH +: DATA_WIDTH] = bar[2'(2 - (k % 3))] ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
    end
    return pix;
  endfunction

  assign hoff_s = h_cnt_r - hact_start_s;
`endif

  assign htot_s       = HW'(hfp_r) + HW'(hsw_r) + HW'(hbp_r) + HW'(hact_r);
  assign hsw_end_s    = HW'(hfp_r) + HW'(hsw_r);
  assign hact_start_s = hsw_end_s + HW'(hbp_r);
  assign vtot_s       = VW'(vfp_r) + VW'(vsw_r) + VW'(vbp_r) + VW'(vact_r);
  assign vsw_end_s    = VW'(vfp_r) + VW'(vsw_r);
  assign vact_start_s = vsw_end_s + VW'(vbp_r);

  // A total of 0 or 1 makes every cycle the last one of its period.
  assign h_last_s      = (h_cnt_r + H_ONE) >= htot_s;
  assign v_last_s      = (v_cnt_r + V_ONE) >= vtot_s;
  assign shadow_load_s = sync_en & h_last_s & v_last_s & (pend_r | cfg_load_i);

  assign h_sync_s = (h_cnt_r >= HW'(hfp_r)) && (h_cnt_r < hsw_end_s);
  assign h_act_s  = h_cnt_r >= hact_start_s;
  assign v_sync_s = (v_cnt_r >= VW'(vfp_r)) && (v_cnt_r < vsw_end_s);
  assign v_act_s  = v_cnt_r >= vact_start_s;
  assign active_s = sync_en & h_act_s & v_act_s;
`ifdef VOUT_TIMING_TEST_PATTERN_EN
  assign ready_s  = active_s & ~test_pat_i;
`else
  assign ready_s  = active_s;
`endif
  assign uf_set_s = ready_s & ~pix_valid_i;

  // Next counter position.
  always_comb begin
    h_cnt_nxt_s = '0;
    v_cnt_nxt_s = '0;
    if (!sync_en) begin
      h_cnt_nxt_s = '0;
      v_cnt_nxt_s = '0;
    end else if (h_last_s) begin
      h_cnt_nxt_s = '0;
      if (v_last_s) begin
        v_cnt_nxt_s = '0;
      end else begin
        v_cnt_nxt_s = v_cnt_r + V_ONE;
      end
    end else begin
      h_cnt_nxt_s = h_cnt_r + H_ONE;
      v_cnt_nxt_s = v_cnt_r;
    end
  end

  // Next output pixel and underflow flag.
  always_comb begin
    data_nxt_s = '0;
`ifdef VOUT_TIMING_TEST_PATTERN_EN
    if (test_pat_i && active_s) begin
      data_nxt_s = bar_pixel(hoff_s[6:4]);
    end else if (ready_s && pix_valid_i) begin
      data_nxt_s = pix_data_i;
    end else begin
      data_nxt_s = '0;
    end
`else
    if (ready_s && pix_valid_i) begin
      data_nxt_s = pix_data_i;
    end else begin
      data_nxt_s = '0;
    end
`endif
    if (uf_set_s) begin
      uf_nxt_s = 1'b1;
    end else if (underflow_clr_i) begin
      uf_nxt_s = 1'b0;
    end else begin
      uf_nxt_s = underflow_r;
    end
  end

  // Shadow config: tracks inputs while idle, otherwise loads only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {hfp_r, hsw_r, hbp_r, hact_r} <= '0;
      {vfp_r, vsw_r, vbp_r, vact_r} <= '0;
      hpol_r <= 1'b0;
      vpol_r <= 1'b0;
      pend_r <= 1'b0;
    end else if (!sync_en || shadow_load_s) begin
      {hfp_r, hsw_r, hbp_r, hact_r} <= {hfp_i, hsw_i, hbp_i, hactive_i};
      {vfp_r, vsw_r, vbp_r, vact_r} <= {vfp_i, vsw_i, vbp_i, vactive_i};
      hpol_r <= hpol_i;
      vpol_r <= vpol_i;
      pend_r <= 1'b0;
    end else if (cfg_load_i) begin
      pend_r <= 1'b1;
    end
  end

  // Counters and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r     <= '0;
      v_cnt_r     <= '0;
      hsync_r     <= 1'b0;
      vsync_r     <= 1'b0;
      de_r        <= 1'b0;
      fs_r        <= 1'b0;
      pix_data_r  <= '0;
      underflow_r <= 1'b0;
    end else begin
      h_cnt_r     <= h_cnt_nxt_s;
      v_cnt_r     <= v_cnt_nxt_s;
      hsync_r     <= (sync_en & h_sync_s) ^ hpol_r;
      vsync_r     <= (sync_en & v_sync_s) ^ vpol_r;
      de_r        <= active_s;
      fs_r        <= sync_en & (h_cnt_r == '0) & (v_cnt_r == '0);
      pix_data_r  <= data_nxt_s;
      underflow_r <= uf_nxt_s;
    end
  end

  assign pix_ready_o   = ready_s;
  assign pix_data_o    = pix_data_r;
  assign hsync_o       = hsync_r;
  assign vsync_o       = vsync_r;
  assign de_o          = de_r;
  assign frame_start_o = fs_r;
  assign underflow_o   = underflow_r;

endmodule

// File: tb/tb_vout_timing_gen.sv
// Directed bench for vout_timing_gen: timing, polarity, handshake/underflow, shadow update, async reset.
`timescale 1ns/1ps
module tb_vout_timing_gen;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_en = 1'b0;
  logic          cfg_load_i = 1'b0;
  logic          hpol_i = 1'b0;
  logic          vpol_i = 1'b0;
  logic [HW-1:0] hfp_i, hsw_i, hbp_i, hactive_i;
  logic [VW-1:0] vfp_i, vsw_i, vbp_i, vactive_i;
  logic [PW-1:0] pix_data_i = '0;
  logic          pix_valid_i = 1'b1;
  logic          underflow_clr_i = 1'b0;
`ifdef VOUT_TIMING_TEST_PATTERN_EN
  logic          test_pat_i = 1'b0;
`endif
  logic          pix_ready_o, hsync_o, vsync_o, de_o, frame_start_o, underflow_o;
  logic [PW-1:0] pix_data_o;

  int checks = 0;
  int errors = 0;

  // Bench model state: shadow config, pending flag, counters, sticky flag.
  int m_hfp, m_hsw, m_hbp, m_hact, m_vfp, m_vsw, m_vbp, m_vact, m_hpol, m_vpol;
  int m_pend, m_h, m_v, m_uf;
  int tcount = 0;
  int n_hs, n_vs, n_de, n_fs, fs_last, fs_prev;

  vout_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW), .DATA_WIDTH(8), .NUM_CH(3)) dut (
    .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .cfg_load_i(cfg_load_i),
    .hpol_i(hpol_i), .vpol_i(vpol_i),
    .hfp_i(hfp_i), .hsw_i(hsw_i), .hbp_i(hbp_i), .hactive_i(hactive_i),
    .vfp_i(vfp_i), .vsw_i(vsw_i), .vbp_i(vbp_i), .vactive_i(vactive_i),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .underflow_clr_i(underflow_clr_i),
`ifdef VOUT_TIMING_TEST_PATTERN_EN
    .test_pat_i(test_pat_i),
`endif
    .pix_ready_o(pix_ready_o), .pix_data_o(pix_data_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .de_o(de_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_shadow();
    m_hfp = int'(hfp_i); m_hsw = int'(hsw_i); m_hbp = int'(hbp_i); m_hact = int'(hactive_i);
    m_vfp = int'(vfp_i); m_vsw = int'(vsw_i); m_vbp = int'(vbp_i); m_vact = int'(vactive_i);
    m_hpol = int'(hpol_i); m_vpol = int'(vpol_i);
  endtask

  task automatic model_reset();
    m_hfp = 0; m_hsw = 0; m_hbp = 0; m_hact = 0; m_vfp = 0; m_vsw = 0; m_vbp = 0; m_vact = 0;
    m_hpol = 0; m_vpol = 0; m_pend = 0; m_h = 0; m_v = 0; m_uf = 0;
  endtask

  task automatic zero_counts();
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0;
  endtask

  // Colour bars: bar 0 white, bar 1 yellow, ...; channel k lit when bar bit (2-k) is clear.
  function automatic logic [PW-1:0] bars(input int off);
    logic [2:0]    bar;
    logic [PW-1:0] pix;
    bar = 3'((off >> 4) & 7);
    pix = '0;
    for (int k = 0; k < 3; k++) pix[k*8 +: 8] = bar[2-k] ? 8'h00 : 8'hFF;
    return pix;
  endfunction

  // One pixel clock: drive data, check ready, advance model, check registered outputs.
  task automatic tick();
    int htot, vtot, hstart, vstart;
    bit hs, vs, act, rdy, tp, fs, hl, vl;
    logic [PW-1:0] exp_data;
    logic exp_hs, exp_vs;
    tcount++;
    pix_data_i = 24'(tcount * 7919 + 17);
    #1;
    htot   = m_hfp + m_hsw + m_hbp + m_hact;
    vtot   = m_vfp + m_vsw + m_vbp + m_vact;
    hstart = m_hfp + m_hsw + m_hbp;
    vstart = m_vfp + m_vsw + m_vbp;
    hs  = sync_en && (m_h >= m_hfp) && (m_h < m_hfp + m_hsw);
    vs  = sync_en && (m_v >= m_vfp) && (m_v < m_vfp + m_vsw);
    act = sync_en && (m_h >= hstart) && (m_v >= vstart);
    tp  = 1'b0;
`ifdef VOUT_TIMING_TEST_PATTERN_EN
    tp  = test_pat_i;
`endif
    rdy = act && !tp;
    chk("pix_ready", pix_ready_o, rdy);
    exp_data = '0;
    if (tp && act) exp_data = bars(m_h - hstart);
    else if (rdy && pix_valid_i) exp_data = pix_data_i;
    if (rdy && !pix_valid_i) m_uf = 1;
    else if (underflow_clr_i) m_uf = 0;
    fs = sync_en && (m_h == 0) && (m_v == 0);
    exp_hs = hs ^ m_hpol[0];
    exp_vs = vs ^ m_vpol[0];
    if (!sync_en) begin
      m_h = 0; m_v = 0; m_pend = 0;
      load_shadow();
    end else begin
      hl = (m_h + 1 >= htot);
      vl = (m_v + 1 >= vtot);
      if (hl && vl && (m_pend != 0 || cfg_load_i)) begin
        load_shadow();
        m_pend = 0;
      end else if (cfg_load_i) begin
        m_pend = 1;
      end
      if (hl) begin
        m_h = 0;
        m_v = vl ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    @(negedge clk);
    chk("hsync", hsync_o, exp_hs);
    chk("vsync", vsync_o, exp_vs);
    chk("de", de_o, act);
    chk("frame_start", frame_start_o, fs);
    chk("pix_data", pix_data_o, exp_data);
    chk("underflow", underflow_o, m_uf[0]);
    n_hs += int'(hsync_o);
    n_vs += int'(vsync_o);
    n_de += int'(de_o);
    if (frame_start_o) begin
      n_fs++;
      fs_prev = fs_last;
      fs_last = tcount;
    end
  endtask

  task automatic run_to(input int h, input int v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (m_h == h && m_v == v) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("run_to_reached", ok, 1'b1);
  endtask

  initial begin
    hfp_i = 12'd2; hsw_i = 12'd3; hbp_i = 12'd4; hactive_i = 12'd8;
    vfp_i = 12'd1; vsw_i = 12'd2; vbp_i = 12'd1; vactive_i = 12'd3;
    model_reset();
    zero_counts();
    fs_last = 0; fs_prev = 0;

    // Reset state.
    #12;
    chk("rst_hsync", hsync_o, 1'b0);
    chk("rst_vsync", vsync_o, 1'b0);
    chk("rst_de", de_o, 1'b0);
    chk("rst_fs", frame_start_o, 1'b0);
    chk("rst_data", pix_data_o, 24'h0);
    chk("rst_uf", underflow_o, 1'b0);
    chk("rst_ready", pix_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Timing: htot=17, vtot=7, frame of 119 cycles.
    sync_en = 1'b1;
    zero_counts();
    repeat (119) tick();
    chk("frame_hsync_cycles", n_hs, 21);
    chk("frame_vsync_cycles", n_vs, 34);
    chk("frame_de_cycles", n_de, 24);
    chk("frame_fs_pulses", n_fs, 1);
    repeat (119) tick();
    chk("frame_period", fs_last - fs_prev, 119);

    // Underflow: one missing pixel mid-line, sticky, clear, clear-vs-set.
    run_to(12, 5);
    pix_valid_i = 1'b0;
    tick();
    pix_valid_i = 1'b1;
    chk("uf_pixel_zero", pix_data_o, 24'h0);
    chk("uf_set", underflow_o, 1'b1);
    repeat (5) tick();
    chk("uf_sticky", underflow_o, 1'b1);
    underflow_clr_i = 1'b1;
    tick();
    underflow_clr_i = 1'b0;
    chk("uf_cleared", underflow_o, 1'b0);
    run_to(13, 6);
    pix_valid_i = 1'b0;
    underflow_clr_i = 1'b1;
    tick();
    pix_valid_i = 1'b1;
    underflow_clr_i = 1'b0;
    chk("uf_set_wins", underflow_o, 1'b1);
    underflow_clr_i = 1'b1;
    tick();
    underflow_clr_i = 1'b0;

    // Shadow update mid-frame: hactive 8 -> 4 applies from next frame.
    run_to(5, 3);
    hactive_i = 12'd4;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    zero_counts();
    run_to(0, 0);
    chk("old_frame_de_cycles", n_de, 24);
    zero_counts();
    repeat (91) tick();
    chk("new_frame_de_cycles", n_de, 12);
    chk("new_frame_hsync_cycles", n_hs, 21);
    tick();
    chk("new_frame_period", fs_last - fs_prev, 91);

    // Polarity: inverted syncs, restoring hactive=8.
    hpol_i = 1'b1; vpol_i = 1'b1; hactive_i = 12'd8;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    run_to(0, 0);
    zero_counts();
    repeat (119) tick();
    chk("inv_hsync_cycles", n_hs, 98);
    chk("inv_vsync_cycles", n_vs, 85);
    sync_en = 1'b0;
    repeat (3) tick();
    chk("idle_hsync_level", hsync_o, 1'b1);
    chk("idle_vsync_level", vsync_o, 1'b1);
    chk("idle_de", de_o, 1'b0);

    // Async reset mid-line, then restart with sync_en held high.
    sync_en = 1'b1;
    repeat (30) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_hsync", hsync_o, 1'b0);
    chk("arst_vsync", vsync_o, 1'b0);
    chk("arst_de", de_o, 1'b0);
    chk("arst_fs", frame_start_o, 1'b0);
    chk("arst_data", pix_data_o, 24'h0);
    chk("arst_uf", underflow_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
    chk("arst_first_fs", frame_start_o, 1'b1);
    repeat (130) tick();

`ifdef VOUT_TIMING_TEST_PATTERN_EN
    // Colour bars over a 128-pixel active line.
    sync_en = 1'b0;
    hpol_i = 1'b0; vpol_i = 1'b0; hactive_i = 12'd128;
    test_pat_i = 1'b1;
    repeat (2) tick();
    sync_en = 1'b1;
    run_to(9, 4);
    tick();
    chk("tp_pixel0", pix_data_o, 24'hFFFFFF);
    run_to(25, 4);
    tick();
    chk("tp_pixel16", pix_data_o, 24'h00FFFF);
    repeat (40) tick();
    chk("tp_no_underflow", underflow_o, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
